pixel_request_arbiter: RTL and testbench

Shares the single NIOS pixel-lookup channel (position PIO in, request PIO in, color PIO out) among NUM_REQ hardware requesters. Requesters post a packed {y,x} pixel position and receive the 24-bit RGB color the NIOS program returns. The block sits between game/render logic and the NIOS_Test system ports. It uses a round-robin arbiter, a fixed-latency response window and an optional single-entry result cache.

---
 rtl/pixel_request_arbiter.sv | 172 +++++++++++++++++
 tb/tb_pixel_request_arbiter.sv | 197 +++++++++++++++++++
 2 files changed

// File: rtl/pixel_request_arbiter.sv
// Round-robin arbiter sharing one NIOS pixel-lookup PIO channel among NUM_REQ requesters.
// Optional single-entry result cache enabled by defining PIXEL_CACHE_EN.
module pixel_request_arbiter #(
  parameter int NUM_REQ     = 4,
  parameter int RESP_CYCLES = 2048
) (
  input  logic                   clk_clk,
  input  logic                   reset_reset_n,
  input  logic [NUM_REQ-1:0]     req_valid,
  input  logic [NUM_REQ*32-1:0]  req_pos,
  output logic [NUM_REQ-1:0]     rsp_valid,
  output logic [23:0]            rsp_color,
  output logic [31:0]            pio_position,
  output logic                   pio_request,
  input  logic [23:0]            pio_color,
  input  logic                   cache_flush,
  output logic                   busy
);
  localparam int PW = $clog2(NUM_REQ);
  localparam int CW = (RESP_CYCLES > 2) ? $clog2(RESP_CYCLES) : 1;

  typedef enum logic [1:0] {IDLE, WAIT, RESP} state_t;

  state_t        state_q, state_d;
  logic [PW-1:0] ptr_q, ptr_d;
  logic [PW-1:0] grant_q, grant_d;
  logic [31:0]   pio_pos_q, pio_pos_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [23:0]   color_q, color_d;

  logic          req_any;
  logic [PW-1:0] win_idx;
  logic [PW-1:0] cand;
  logic [31:0]   win_pos;
  logic          hit;
  logic [23:0]   hit_color;
  int            idx;

  // Scan offsets from highest to lowest so the first requester at or after ptr wins.
  always_comb begin
    req_any = 1'b0;
    win_idx = ptr_q;
    idx     = 0;
    cand    = '0;
    for (int k = NUM_REQ - 1; k >= 0; k--) begin
      idx = int'(ptr_q) + k;
      if (idx >= NUM_REQ) idx = idx - NUM_REQ;
      cand = PW'(idx);
      if (req_valid[cand]) begin
        req_any = 1'b1;
        win_idx = cand;
      end
    end
  end

  assign win_pos = req_pos[32*win_idx +: 32];

`ifdef PIXEL_CACHE_EN
  logic        cvalid_q, cvalid_d;
  logic [31:0] cpos_q, cpos_d;
  logic [23:0] ccolor_q, ccolor_d;
  logic        fill_q, fill_d;

  // A flush in the grant cycle must defeat the hit, so it is folded in here.
  assign hit       = cvalid_q && !cache_flush && (win_pos == cpos_q);
  assign hit_color = ccolor_q;

  always_comb begin
    cvalid_d = cvalid_q;
    cpos_d   = cpos_q;
    ccolor_d = ccolor_q;
    fill_d   = fill_q;
    if (cache_flush) cvalid_d = 1'b0;
    case (state_q)
      IDLE: if (req_any) fill_d = !hit;
      WAIT: if (cache_flush) fill_d = 1'b0;
      RESP: begin
        if (fill_q && !cache_flush) begin
          cvalid_d = 1'b1;
          cpos_d   = pio_pos_q;
          ccolor_d = color_q;
        end
        fill_d = 1'b0;
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk_clk or negedge reset_reset_n) begin
    if (!reset_reset_n) begin
      cvalid_q <= 1'b0;
      cpos_q   <= '0;
      ccolor_q <= '0;
      fill_q   <= 1'b0;
    end else begin
      cvalid_q <= cvalid_d;
      cpos_q   <= cpos_d;
      ccolor_q <= ccolor_d;
      fill_q   <= fill_d;
    end
  end
`else
  logic unused_flush;
  assign unused_flush = cache_flush;
  assign hit          = 1'b0;
  assign hit_color    = '0;
`endif

  always_comb begin
    state_d   = state_q;
    ptr_d     = ptr_q;
    grant_d   = grant_q;
    pio_pos_d = pio_pos_q;
    cnt_d     = cnt_q;
    color_d   = color_q;
    case (state_q)
      IDLE: begin
        if (req_any) begin
          grant_d = win_idx;
          ptr_d   = (win_idx == PW'(NUM_REQ - 1)) ? '0 : win_idx + 1'b1;
          if (hit) begin
            color_d = hit_color;
            state_d = RESP;
          end else begin
            pio_pos_d = win_pos;
            cnt_d     = CW'(RESP_CYCLES - 1);
            state_d   = WAIT;
          end
        end
      end
      WAIT: begin
        if (cnt_q == '0) begin
          color_d = pio_color;
          state_d = RESP;
        end else begin
          cnt_d = cnt_q - 1'b1;
        end
      end
      RESP:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk_clk or negedge reset_reset_n) begin
    if (!reset_reset_n) begin
      state_q   <= IDLE;
      ptr_q     <= '0;
      grant_q   <= '0;
      pio_pos_q <= '0;
      cnt_q     <= '0;
      color_q   <= '0;
    end else begin
      state_q   <= state_d;
      ptr_q     <= ptr_d;
      grant_q   <= grant_d;
      pio_pos_q <= pio_pos_d;
      cnt_q     <= cnt_d;
      color_q   <= color_d;
    end
  end

  always_comb begin
    rsp_valid = '0;
    if (state_q == RESP) rsp_valid[grant_q] = 1'b1;
  end

  assign rsp_color    = color_q;
  assign pio_position = pio_pos_q;
  assign pio_request  = (state_q == WAIT);
  assign busy         = (state_q != IDLE);

endmodule

// File: tb/tb_pixel_request_arbiter.sv
// Directed scoreboard bench for pixel_request_arbiter (NUM_REQ=4, RESP_CYCLES=4).
// Cache-specific steps run when PIXEL_CACHE_EN is defined, cache-off steps otherwise.
module tb_pixel_request_arbiter;
  localparam int NUM_REQ     = 4;
  localparam int RESP_CYCLES = 4;

  logic                  clk_clk = 1'b0;
  logic                  reset_reset_n = 1'b0;
  logic [NUM_REQ-1:0]    req_valid = '0;
  logic [NUM_REQ*32-1:0] req_pos = '0;
  logic [NUM_REQ-1:0]    rsp_valid;
  logic [23:0]           rsp_color;
  logic [31:0]           pio_position;
  logic                  pio_request;
  logic [23:0]           pio_color;
  logic                  cache_flush = 1'b0;
  logic                  busy;

  logic                  use_fn = 1'b0;
  logic [23:0]           fixed_color = '0;

  typedef struct { int idx; logic [23:0] color; } exp_t;
  exp_t sb_q[$];
  int   tests = 0;
  int   fails = 0;

  function automatic logic [23:0] color_fn(input logic [31:0] p);
    return p[23:0] ^ 24'hA5C3E1;
  endfunction

  // NIOS stand-in: either a fixed color or a function of the presented position.
  assign pio_color = use_fn ? color_fn(pio_position) : fixed_color;

  always #5 clk_clk = ~clk_clk;

  pixel_request_arbiter #(.NUM_REQ(NUM_REQ), .RESP_CYCLES(RESP_CYCLES)) dut (
    .clk_clk      (clk_clk),
    .reset_reset_n(reset_reset_n),
    .req_valid    (req_valid),
    .req_pos      (req_pos),
    .rsp_valid    (rsp_valid),
    .rsp_color    (rsp_color),
    .pio_position (pio_position),
    .pio_request  (pio_request),
    .pio_color    (pio_color),
    .cache_flush  (cache_flush),
    .busy         (busy)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    tests++;
    assert (got === exp) else begin
      fails++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic check_rsp(input string tag);
    exp_t e;
    check({tag, "_sb_nonempty"}, 32'(sb_q.size() > 0), 32'd1);
    if (sb_q.size() > 0) begin
      e = sb_q.pop_front();
      check({tag, "_rsp_valid"}, 32'(rsp_valid), 32'(4'b0001 << e.idx));
      check({tag, "_rsp_color"}, 32'(rsp_color), 32'(e.color));
      $display("[TB] %s: rsp req=%0d color=0x%06h", tag, e.idx, rsp_color);
    end
  endtask

  // One request from idx; exp_lat is cycles from the grant-cycle to rsp_valid.
  task automatic serve(input string tag, input int idx, input logic [31:0] pos,
                       input logic [23:0] ecol, input int exp_lat, input int flush_at,
                       input logic [31:0] exp_pio);
    int lat;
    int rq;
    bit seen;
    @(posedge clk_clk); #1;
    req_valid[idx]       = 1'b1;
    req_pos[32*idx +: 32] = pos;
    sb_q.push_back('{idx, ecol});
    lat = 0; rq = 0; seen = 1'b0;
    while (!seen && lat <= 20) begin
      @(negedge clk_clk);
      cache_flush = 1'b0;
      if (pio_request) rq++;
      if (rsp_valid != '0) seen = 1'b1;
      else begin
        if (lat == flush_at) cache_flush = 1'b1;
        lat++;
      end
    end
    cache_flush = 1'b0;
    check({tag, "_rsp_seen"}, 32'(seen), 32'd1);
    check({tag, "_latency"}, lat, exp_lat);
    check({tag, "_pio_req_cycles"}, rq, exp_lat - 1);
    check({tag, "_pio_position"}, pio_position, exp_pio);
    if (seen) check_rsp(tag);
    @(posedge clk_clk); #1;
    req_valid[idx] = 1'b0;
    @(negedge clk_clk);
    check({tag, "_busy_after"}, 32'(busy), 32'd0);
  endtask

  initial begin
    int cyc;
    int last;
    int n;

    // Reset values
    #1;
    check("rst_rsp_valid", 32'(rsp_valid), 0);
    check("rst_rsp_color", 32'(rsp_color), 0);
    check("rst_pio_position", pio_position, 0);
    check("rst_pio_request", 32'(pio_request), 0);
    check("rst_busy", 32'(busy), 0);
    @(negedge clk_clk);
    reset_reset_n = 1'b1;

    // Single miss on requester 2
    fixed_color = 24'hFF8800;
    serve("single", 2, 32'h0010_0020, 24'hFF8800, RESP_CYCLES + 1, -1, 32'h0010_0020);

    // Async reset in WAIT cycle 2
    @(posedge clk_clk); #1;
    req_valid[1]     = 1'b1;
    req_pos[63:32]   = 32'h0007_0008;
    repeat (3) @(negedge clk_clk);
    check("rstw_pio_req_before", 32'(pio_request), 1);
    #1 reset_reset_n = 1'b0;
    #1;
    check("rstw_pio_request", 32'(pio_request), 0);
    check("rstw_busy", 32'(busy), 0);
    check("rstw_rsp_valid", 32'(rsp_valid), 0);
    check("rstw_pio_position", pio_position, 0);
    check("rstw_rsp_color", 32'(rsp_color), 0);
    req_valid = '0;
    @(negedge clk_clk);
    reset_reset_n = 1'b1;

    // No requests: stays idle
    for (int i = 0; i < 4; i++) begin
      @(negedge clk_clk);
      check("idle_busy", 32'(busy), 0);
      check("idle_rsp_valid", 32'(rsp_valid), 0);
      check("idle_pio_request", 32'(pio_request), 0);
    end

    // All four requesting continuously: rotation 0,1,2,3,0 from ptr=0
    use_fn = 1'b1;
    @(posedge clk_clk); #1;
    for (int i = 0; i < NUM_REQ; i++)
      req_pos[32*i +: 32] = {16'(i + 1), 16'(32'h40 + i)};
    req_valid = 4'b1111;
    for (int i = 0; i < 5; i++)
      sb_q.push_back('{i % NUM_REQ, color_fn({16'((i % NUM_REQ) + 1), 16'(32'h40 + (i % NUM_REQ))})});
    cyc = 0; last = 0; n = 0;
    while (n < 5 && cyc < 60) begin
      @(negedge clk_clk);
      if (rsp_valid != '0) begin
        if (n == 0) check("rot_first_latency", cyc, RESP_CYCLES + 1);
        else        check("rot_gap", cyc - last, RESP_CYCLES + 2);
        check_rsp("rot");
        last = cyc;
        n++;
      end
      cyc++;
    end
    check("rot_count", n, 5);
    @(posedge clk_clk); #1;
    req_valid = '0;
    use_fn    = 1'b0;
    repeat (2) @(negedge clk_clk);
    check("rot_busy_after", 32'(busy), 0);
    check("rot_sb_drained", sb_q.size(), 0);

`ifdef PIXEL_CACHE_EN
    fixed_color = 24'h123456;
    serve("c_miss", 1, 32'h0003_0004, 24'h123456, RESP_CYCLES + 1, -1, 32'h0003_0004);
    fixed_color = 24'h654321;
    serve("c_hit", 1, 32'h0003_0004, 24'h123456, 1, -1, 32'h0003_0004);
    serve("c_flush_wait", 1, 32'h0005_0006, 24'h654321, RESP_CYCLES + 1, 2, 32'h0005_0006);
    serve("c_after_flush", 1, 32'h0005_0006, 24'h654321, RESP_CYCLES + 1, -1, 32'h0005_0006);
    fixed_color = 24'h111111;
    serve("c_hit2", 1, 32'h0005_0006, 24'h654321, 1, -1, 32'h0005_0006);
    serve("c_flush_idle", 1, 32'h0005_0006, 24'h111111, RESP_CYCLES + 1, 0, 32'h0005_0006);
`else
    fixed_color = 24'h0ABCDE;
    serve("nc_first", 1, 32'h0003_0004, 24'h0ABCDE, RESP_CYCLES + 1, -1, 32'h0003_0004);
    fixed_color = 24'h0BCDEF;
    serve("nc_repeat", 1, 32'h0003_0004, 24'h0BCDEF, RESP_CYCLES + 1, -1, 32'h0003_0004);
    serve("nc_flush_idle", 1, 32'h0003_0004, 24'h0BCDEF, RESP_CYCLES + 1, 0, 32'h0003_0004);
    serve("nc_flush_wait", 1, 32'h0003_0004, 24'h0BCDEF, RESP_CYCLES + 1, 2, 32'h0003_0004);
`endif

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
